gate_truth_checker: RTL
=======================

# gate_truth_checker

Sequential exerciser for the switch-level gate library (NOT, NAND, NOR, AND, OR, XOR). On a start request it sweeps all four input combinations into one gate under test and samples the gate's output after a programmable settle time. It compares each sample against the expected truth table and reports a per-vector error mask and a pass flag. It is the stimulus-and-check end of the gate library's two-input interface and sits in the lab bench beside the device under test.

## Interface

Parameters:
- SETTLE, default 2: extra cycles each vector is held before sampling; legal range 0..15.

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- gate_sel  input  3  expected function, captured at start: 0 NOT (out = ~a), 1 NAND, 2 NOR, 3 AND, 4 OR, 5 XOR; 6 and 7 are invalid.
- dut_a  output  1  drives gate input a.
- dut_b  output  1  drives gate input b.
- dut_out  input  1  gate output under test.
- busy  output  1  high from start acceptance until the done cycle ends.
- done  output  1  one-cycle pulse when results are valid.
- pass  output  1  high when all 4 vectors matched; valid from done until the next accepted start.
- err_mask  output  4  bit k set when vector k mismatched.
- err_count  output  3  number of mismatching vectors, 0..4.

## Operation

- States: IDLE, RUN, DONE.
- Vector k (0..3) drives dut_a = k[1] and dut_b = k[0].
- IDLE:
  - dut_a = dut_b = 0.
  - On start=1, capture gate_sel, clear err_mask, err_count and pass, load k=0 and settle counter = SETTLE, then enter RUN.
- RUN:
  - Hold vector k while the settle counter is non-zero; decrement it each cycle.
  - When the counter reaches 0, sample dut_out on that edge and compare it to the expected value using 4-state equality.
  - A dut_out of x or z is a mismatch. Switch-level gates can float, and a float must be flagged, not masked.
  - On mismatch, set err_mask[k] and increment err_count.
  - If k < 3, advance to k+1 on the same edge and reload the counter with SETTLE.
  - If k = 3, enter DONE.
- DONE:
  - done=1 for exactly one cycle.
  - pass = (err_count == 0), evaluated including the final vector.
  - Return to IDLE.
  - dut_a/dut_b return to 0 on entry to IDLE.
- Invalid gate_sel (6 or 7):
  - No vectors are driven (dut_a/dut_b stay 0).
  - Go directly to DONE.
  - Report err_mask = 4'hF, err_count = 4, pass = 0.
- start while busy is ignored. gate_sel changes after capture have no effect.
- NOT ignores b; all four vectors are still applied.
- Results (pass, err_mask, err_count) hold their values in IDLE until the next accepted start clears them.

## Timing

- Reset values:
  - State IDLE.
  - dut_a=0, dut_b=0.
  - busy=0, done=0, pass=0.
  - err_mask=0, err_count=0.
- Reset asserted mid-sweep aborts immediately: outputs go to reset values and no done pulse is produced.
- Each vector is held for SETTLE+1 cycles and sampled on its last edge.
- Let start be accepted at edge E0:
  - Vector k is driven from E0 + k·(SETTLE+1).
  - Vector k is sampled at E0 + (k+1)·(SETTLE+1).
  - done is high in the cycle following edge E0 + 4·(SETTLE+1).
  - SETTLE=2 gives done 12 cycles after acceptance; SETTLE=0 gives 4.
- Invalid gate_sel: done is high in the cycle after E0.
- busy rises after E0 and falls with the edge that ends the done cycle.
- Back-to-back operation: start held high is accepted again in the first IDLE cycle after done, so consecutive sweeps have exactly one IDLE cycle between them.

## Test plan

- Reset, then idle: all outputs 0 and dut_a/dut_b=0; start asserted during reset is not accepted.
- gate_sel=5 (XOR) against a correct XOR gate, SETTLE=2 -> vectors 00,01,10,11 each held 3 cycles; done 12 cycles after start; pass=1, err_mask=0, err_count=0.
- gate_sel=1 (NAND) against an AND gate -> err_mask=4'hF, err_count=4, pass=0.
- gate_sel=2 (NOR) with dut_out forced to z on vector 3 only -> err_mask=4'b1000, err_count=1, pass=0.
- gate_sel=7 -> done in the cycle after start, err_mask=4'hF, pass=0, dut_a/dut_b never leave 0. Then start with gate_sel=0 against a NOT gate -> pass=1.
- rst pulsed while k=2 -> all outputs return to 0, no done pulse. A new start then runs a full, clean sweep; a start pulse issued mid-sweep is ignored without extending latency.

Source files
------------

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps four input vectors into a gate under test and checks its truth table
module gate_truth_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] count_q, count_d;
    logic       pass_q, pass_d;
    logic       exp_out, mismatch;

    // State and result registers; reset aborts any sweep without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    // Expected output for the current vector; x/z on dut_out must count as a mismatch
    always_comb begin
        exp_out = sel_q == 3'd0 ? ~k_q[1] :
                  sel_q == 3'd1 ? ~&k_q :
                  sel_q == 3'd2 ? ~|k_q :
                  sel_q == 3'd3 ? &k_q :
                  sel_q == 3'd4 ? |k_q : ^k_q;
        mismatch = dut_out !== exp_out;
    end

    // Next state: invalid selections skip straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (gate_sel > 3'd5) ? DONE : RUN;
            RUN:     if (cnt_q == 4'd0 && k_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Vector sequencing, settle counting and result accumulation
    always_comb begin
        k_d     = k_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        count_d = count_q;
        pass_d  = pass_q;
        if (state_q == IDLE && start) begin
            sel_d   = gate_sel;
            k_d     = 2'd0;
            cnt_d   = 4'(SETTLE);
            mask_d  = (gate_sel > 3'd5) ? 4'hF : 4'h0;
            count_d = (gate_sel > 3'd5) ? 3'd4 : 3'd0;
            pass_d  = 1'b0;
        end else if (state_q == RUN) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                mask_d[k_q] = mask_q[k_q] | mismatch;
                count_d     = count_q + {2'b00, mismatch};
                k_d         = k_q + 2'd1;
                cnt_d       = 4'(SETTLE);
                pass_d      = (k_q == 2'd3) && !mismatch && count_q == 3'd0;
            end
        end
    end

    // Outputs: vectors only driven while running
    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        dut_a     = state_q == RUN && k_q[1];
        dut_b     = state_q == RUN && k_q[0];
        pass      = pass_q;
        err_mask  = mask_q;
        err_count = count_q;
    end
endmodule
